// File: rtl/atm_keypad_entry_if.sv
// Keypad entry bus: key strobes in, login/command offers out with valid/ready.
// Latency: none; this is wiring only.
// Backpressure: login_ready/cmd_ready hold the corresponding offer.
interface atm_keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic [2:0]  menu_option;
  logic [10:0] amount;
  logic [11:0] dest_acc_number;
  logic        login_valid;
  logic        login_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        exit;
  logic        entry_error;

  // Side that presses keys and consumes the offers.
  modport master (
    output key_valid, key_code, login_ready, cmd_ready,
    input  acc_number, pin, menu_option, amount, dest_acc_number,
    input  login_valid, cmd_valid, exit, entry_error
  );

  // The keypad entry block itself.
  modport slave (
    input  key_valid, key_code, login_ready, cmd_ready,
    output acc_number, pin, menu_option, amount, dest_acc_number,
    output login_valid, cmd_valid, exit, entry_error
  );
endinterface

// File: rtl/atm_keypad_entry.sv
// ATM keypad entry: assembles account/PIN, menu choice, amount and destination from key strobes.
// Latency: one cycle from a sampled key to updated fields, valids and error/exit pulses.
// Backpressure: login/command offers are held frozen until the matching ready is sampled.
module atm_keypad_entry (
  input  logic                  clk,
  input  logic                  reset_n,
  atm_keypad_entry_if.slave     bus
);

  typedef enum logic [2:0] {
    ACC, PIN, LOGIN_OUT, MENU, AMOUNT, DEST, CMD_OUT
  } state_t;

  localparam logic [3:0] K_CLEAR  = 4'd10;
  localparam logic [3:0] K_ENTER  = 4'd11;
  localparam logic [3:0] K_CANCEL = 4'd12;

  state_t      state, state_nxt;
  logic [11:0] acc, acc_nxt;
  logic [3:0]  pin, pin_nxt;
  logic [3:0]  menu, menu_nxt;      // keeps 8/9 so they can be rejected on ENTER
  logic [10:0] amt, amt_nxt;
  logic [11:0] dest, dest_nxt;
  logic [2:0]  cnt, cnt_nxt;        // digits typed into the field currently being edited
  logic        login_vld, login_vld_nxt;
  logic        cmd_vld, cmd_vld_nxt;
  logic        exit_q, exit_nxt;
  logic        err_q, err_nxt;

  logic [11:0] cur;
  logic [11:0] lim;
  logic [2:0]  max_cnt;
  logic [15:0] cand;
  logic        digit_ok;
  logic        is_digit;

  // Active field, its value limit and digit budget, and the candidate after appending a digit.
  always_comb begin
    cur     = 12'd0;
    lim     = 12'd0;
    max_cnt = 3'd0;
    case (state)
      ACC:    begin cur = acc;              lim = 12'd4095; max_cnt = 3'd4; end
      PIN:    begin cur = {8'd0, pin};      lim = 12'd9;    max_cnt = 3'd1; end
      MENU:   begin cur = {8'd0, menu};     lim = 12'd9;    max_cnt = 3'd1; end
      AMOUNT: begin cur = {1'b0, amt};      lim = 12'd2047; max_cnt = 3'd4; end
      DEST:   begin cur = dest;             lim = 12'd4095; max_cnt = 3'd4; end
      default: begin cur = 12'd0;           lim = 12'd0;    max_cnt = 3'd0; end
    endcase
    is_digit = (bus.key_code <= 4'd9);
    cand     = {4'd0, cur} * 16'd10 + {12'd0, bus.key_code};
    digit_ok = (cnt < max_cnt) && (cand <= {4'd0, lim});
  end

  // Next-state and next-field logic; CANCEL wins over everything, including a same-cycle ready.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    pin_nxt   = pin;
    menu_nxt  = menu;
    amt_nxt   = amt;
    dest_nxt  = dest;
    cnt_nxt   = cnt;
    exit_nxt  = 1'b0;
    err_nxt   = 1'b0;

    if (bus.key_valid && bus.key_code == K_CANCEL) begin
      state_nxt = ACC;
      acc_nxt   = 12'd0;
      pin_nxt   = 4'd0;
      menu_nxt  = 4'd0;
      amt_nxt   = 11'd0;
      dest_nxt  = 12'd0;
      cnt_nxt   = 3'd0;
      exit_nxt  = 1'b1;
    end else begin
      case (state)
        LOGIN_OUT: begin
          // Keys are ignored while the login offer is outstanding.
          if (bus.login_ready) begin
            state_nxt = MENU;
            cnt_nxt   = 3'd0;
          end
        end
        CMD_OUT: begin
          if (bus.cmd_ready) begin
            state_nxt = MENU;
            menu_nxt  = 4'd0;
            amt_nxt   = 11'd0;
            dest_nxt  = 12'd0;
            cnt_nxt   = 3'd0;
          end
        end
        default: begin
          if (bus.key_valid) begin
            if (is_digit) begin
              if (digit_ok) begin
                cnt_nxt = cnt + 3'd1;
                case (state)
                  ACC:     acc_nxt  = cand[11:0];
                  PIN:     pin_nxt  = cand[3:0];
                  MENU:    menu_nxt = cand[3:0];
                  AMOUNT:  amt_nxt  = cand[10:0];
                  DEST:    dest_nxt = cand[11:0];
                  default: cnt_nxt  = cnt;
                endcase
              end else begin
                err_nxt = 1'b1;
              end
            end else if (bus.key_code == K_CLEAR) begin
              cnt_nxt = 3'd0;
              case (state)
                ACC:     acc_nxt  = 12'd0;
                PIN:     pin_nxt  = 4'd0;
                MENU:    menu_nxt = 4'd0;
                AMOUNT:  amt_nxt  = 11'd0;
                DEST:    dest_nxt = 12'd0;
                default: cnt_nxt  = cnt;
              endcase
            end else if (bus.key_code == K_ENTER) begin
              if (cnt == 3'd0) begin
                err_nxt = 1'b1;
              end else begin
                cnt_nxt = 3'd0;
                case (state)
                  ACC: state_nxt = PIN;
                  PIN: state_nxt = LOGIN_OUT;
                  MENU: begin
                    case (menu)
                      4'd3:             state_nxt = CMD_OUT;
                      4'd4, 4'd5, 4'd6: state_nxt = AMOUNT;
                      4'd7: begin
                        state_nxt = ACC;
                        exit_nxt  = 1'b1;
                        acc_nxt   = 12'd0;
                        pin_nxt   = 4'd0;
                        menu_nxt  = 4'd0;
                        amt_nxt   = 11'd0;
                        dest_nxt  = 12'd0;
                      end
                      default: begin
                        err_nxt  = 1'b1;
                        menu_nxt = 4'd0;
                      end
                    endcase
                  end
                  AMOUNT:  state_nxt = (menu == 4'd6) ? DEST : CMD_OUT;
                  DEST:    state_nxt = CMD_OUT;
                  default: state_nxt = state;
                endcase
              end
            end else begin
              // Codes 13-15 are not keys we know.
              err_nxt = 1'b1;
            end
          end
        end
      endcase
    end

    login_vld_nxt = (state_nxt == LOGIN_OUT);
    cmd_vld_nxt   = (state_nxt == CMD_OUT);
  end

  // State and all registered outputs; reset drops any outstanding offer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ACC;
      acc       <= 12'd0;
      pin       <= 4'd0;
      menu      <= 4'd0;
      amt       <= 11'd0;
      dest      <= 12'd0;
      cnt       <= 3'd0;
      login_vld <= 1'b0;
      cmd_vld   <= 1'b0;
      exit_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      pin       <= pin_nxt;
      menu      <= menu_nxt;
      amt       <= amt_nxt;
      dest      <= dest_nxt;
      cnt       <= cnt_nxt;
      login_vld <= login_vld_nxt;
      cmd_vld   <= cmd_vld_nxt;
      exit_q    <= exit_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.acc_number      = acc;
  assign bus.pin             = pin;
  assign bus.menu_option     = menu[2:0];
  assign bus.amount          = amt;
  assign bus.dest_acc_number = dest;
  assign bus.login_valid     = login_vld;
  assign bus.cmd_valid       = cmd_vld;
  assign bus.exit            = exit_q;
  assign bus.entry_error     = err_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry with hand-computed expectations.
// Keys are driven on the falling edge and outputs sampled on the following falling edge.
// Offers are held by leaving ready low for several cycles before accepting.
module tb_atm_keypad_entry;
  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  localparam logic [3:0] K_CLR = 4'd10;
  localparam logic [3:0] K_ENT = 4'd11;
  localparam logic [3:0] K_CAN = 4'd12;

  atm_keypad_entry_if bus();

  atm_keypad_entry dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset_n         = 1'b0;
    bus.key_valid   = 1'b1;   // key held during reset must be ignored
    bus.key_code    = 4'd5;
    bus.login_ready = 1'b0;
    bus.cmd_ready   = 1'b0;
    idle(3);
    chk("rst_acc",   16'(bus.acc_number), 16'd0);
    chk("rst_lvld",  16'(bus.login_valid), 16'd0);
    chk("rst_cvld",  16'(bus.cmd_valid), 16'd0);
    chk("rst_exit",  16'(bus.exit), 16'd0);
    chk("rst_err",   16'(bus.entry_error), 16'd0);
    bus.key_valid = 1'b0;
    reset_n       = 1'b1;

    // ACC: empty ENTER, then 4096 overflow
    press(K_ENT);
    chk("acc_empty_ent_err", 16'(bus.entry_error), 16'd1);
    press(4'd4); press(4'd0); press(4'd9);
    chk("acc_409", 16'(bus.acc_number), 16'd409);
    chk("acc_409_noerr", 16'(bus.entry_error), 16'd0);
    press(4'd6);
    chk("acc_ovf_err", 16'(bus.entry_error), 16'd1);
    chk("acc_ovf_hold", 16'(bus.acc_number), 16'd409);
    idle(1);
    chk("acc_err_one_cycle", 16'(bus.entry_error), 16'd0);
    press(4'd15);
    chk("bad_code_err", 16'(bus.entry_error), 16'd1);
    press(K_CLR);
    chk("acc_clr", 16'(bus.acc_number), 16'd0);
    chk("acc_clr_noerr", 16'(bus.entry_error), 16'd0);

    // Login 2178 / 4
    press(4'd2); press(4'd1); press(4'd7); press(4'd8); press(K_ENT);
    press(4'd4);
    press(4'd5);
    chk("pin_one_digit_err", 16'(bus.entry_error), 16'd1);
    chk("pin_hold", 16'(bus.pin), 16'd4);
    press(K_ENT);
    chk("login_vld", 16'(bus.login_valid), 16'd1);
    chk("login_acc", 16'(bus.acc_number), 16'd2178);
    chk("login_pin", 16'(bus.pin), 16'd4);
    press(4'd9);
    idle(2);
    chk("login_hold_vld", 16'(bus.login_valid), 16'd1);
    chk("login_frozen_pin", 16'(bus.pin), 16'd4);
    chk("login_key_silent", 16'(bus.entry_error), 16'd0);
    bus.login_ready = 1'b1;
    idle(1);
    bus.login_ready = 1'b0;
    chk("login_accept", 16'(bus.login_valid), 16'd0);

    // Menu 5, amount 100
    press(4'd5); press(K_ENT);
    press(4'd1); press(4'd0); press(4'd0); press(K_ENT);
    chk("cmd5_vld", 16'(bus.cmd_valid), 16'd1);
    chk("cmd5_menu", 16'(bus.menu_option), 16'd5);
    chk("cmd5_amt", 16'(bus.amount), 16'd100);
    idle(3);
    chk("cmd5_hold", 16'(bus.cmd_valid), 16'd1);
    chk("cmd5_hold_amt", 16'(bus.amount), 16'd100);
    bus.cmd_ready = 1'b1;
    idle(1);
    bus.cmd_ready = 1'b0;
    chk("cmd5_accept", 16'(bus.cmd_valid), 16'd0);
    chk("cmd5_amt_clr", 16'(bus.amount), 16'd0);
    chk("cmd5_menu_clr", 16'(bus.menu_option), 16'd0);
    chk("login_retained", 16'(bus.acc_number), 16'd2178);

    // Menu 4: amount 255, 2550 rejected, CLEAR, then 7
    press(4'd4); press(K_ENT);
    press(4'd2); press(4'd5); press(4'd5);
    chk("amt_255", 16'(bus.amount), 16'd255);
    press(4'd0);
    chk("amt_ovf_err", 16'(bus.entry_error), 16'd1);
    chk("amt_ovf_hold", 16'(bus.amount), 16'd255);
    press(K_CLR);
    chk("amt_clr", 16'(bus.amount), 16'd0);
    press(4'd7); press(K_ENT);
    chk("cmd4_vld", 16'(bus.cmd_valid), 16'd1);
    chk("cmd4_amt", 16'(bus.amount), 16'd7);
    bus.cmd_ready = 1'b1;
    idle(1);
    bus.cmd_ready = 1'b0;
    chk("cmd4_accept", 16'(bus.cmd_valid), 16'd0);

    // Menu 6: amount 50, dest 2816
    press(4'd6); press(K_ENT);
    press(4'd5); press(4'd0); press(K_ENT);
    chk("dest_no_cmd_yet", 16'(bus.cmd_valid), 16'd0);
    press(4'd2); press(4'd8); press(4'd1); press(4'd6); press(K_ENT);
    chk("cmd6_vld", 16'(bus.cmd_valid), 16'd1);
    chk("cmd6_menu", 16'(bus.menu_option), 16'd6);
    chk("cmd6_amt", 16'(bus.amount), 16'd50);
    chk("cmd6_dest", 16'(bus.dest_acc_number), 16'd2816);
    bus.cmd_ready = 1'b1;
    idle(1);
    bus.cmd_ready = 1'b0;
    chk("cmd6_dest_clr", 16'(bus.dest_acc_number), 16'd0);

    // Invalid menu option, then 3 with CANCEL racing cmd_ready
    press(4'd8); press(K_ENT);
    chk("menu8_err", 16'(bus.entry_error), 16'd1);
    chk("menu8_clr", 16'(bus.menu_option), 16'd0);
    press(4'd3); press(K_ENT);
    chk("cmd3_vld", 16'(bus.cmd_valid), 16'd1);
    chk("cmd3_menu", 16'(bus.menu_option), 16'd3);
    bus.cmd_ready = 1'b1;
    press(K_CAN);
    bus.cmd_ready = 1'b0;
    chk("cancel_exit", 16'(bus.exit), 16'd1);
    chk("cancel_cvld", 16'(bus.cmd_valid), 16'd0);
    chk("cancel_acc", 16'(bus.acc_number), 16'd0);
    chk("cancel_menu", 16'(bus.menu_option), 16'd0);
    idle(1);
    chk("exit_one_cycle", 16'(bus.exit), 16'd0);

    // Quick login then menu 7 ends the session
    press(4'd1); press(K_ENT); press(4'd2); press(K_ENT);
    bus.login_ready = 1'b1;
    idle(1);
    bus.login_ready = 1'b0;
    press(4'd7); press(K_ENT);
    chk("done_exit", 16'(bus.exit), 16'd1);
    chk("done_acc_clr", 16'(bus.acc_number), 16'd0);
    press(4'd3);
    chk("done_back_in_acc", 16'(bus.acc_number), 16'd3);

    // Asynchronous reset while a login offer is outstanding
    press(K_ENT); press(4'd6); press(K_ENT);
    chk("pre_rst_lvld", 16'(bus.login_valid), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_lvld", 16'(bus.login_valid), 16'd0);
    chk("async_rst_acc", 16'(bus.acc_number), 16'd0);
    chk("async_rst_pin", 16'(bus.pin), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    press(4'd9);
    chk("post_rst_key", 16'(bus.acc_number), 16'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/atm_keypad_entry.md
ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset_n  input  1  reset, asynchronous, active-low.
REQ-003 key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
REQ-004 key_code  input  4  0-9 digit, 10 CLEAR, 11 ENTER, 12 CANCEL, 13-15 invalid.
REQ-005 acc_number  output  12  assembled account number, decimal 0-4095.
REQ-006 pin  output  4  assembled PIN, single digit 0-9.
REQ-007 menu_option  output  3  selected operation: 3 BALANCE, 4 WITHDRAW, 5 WITHDRAW_SHOW_BALANCE, 6 TRANSACTION, 7 DONE.
REQ-008 amount  output  11  assembled amount, decimal 0-2047.
REQ-009 dest_acc_number  output  12  assembled destination account, 0-4095.
REQ-010 login_valid  output  1  acc_number/pin stable and offered downstream.
REQ-011 login_ready  input  1  downstream accepts the login offer.
REQ-012 cmd_valid  output  1  menu_option/amount/dest_acc_number stable and offered downstream.
REQ-013 cmd_ready  input  1  downstream accepts the command offer.
REQ-014 exit  output  1  one-cycle pulse ending the session.
REQ-015 entry_error  output  1  one-cycle pulse flagging a rejected key.

Function
REQ-016 States: ACC, PIN, LOGIN_OUT, MENU, AMOUNT, DEST, CMD_OUT; only keys with key_valid=1 are acted on.
REQ-017 Digit entry: field <= field*10 + digit, digit_count+1; ACC/AMOUNT/DEST hold at most 4 digits, PIN 1, MENU 1.
REQ-018 Digit whose result exceeds field limit (ACC/DEST 4095, AMOUNT 2047) or exceeds digit count: ignored, field unchanged, entry_error pulse next cycle.
REQ-019 CLEAR: current field and its digit_count set to 0; no error.
REQ-020 ENTER with digit_count=0: entry_error, stay in state.
REQ-021 ENTER in ACC -> PIN; in PIN -> LOGIN_OUT.
REQ-022 LOGIN_OUT: login_valid=1 and acc_number/pin frozen until login_ready=1 sampled; that edge clears login_valid and -> MENU.
REQ-023 ENTER in MENU: option 3 -> CMD_OUT; 4,5,6 -> AMOUNT; 7 -> exit pulse, clear all fields, -> ACC; 0-2 or 8-9 -> entry_error, menu field cleared, stay.
REQ-024 ENTER in AMOUNT: option 6 -> DEST, else -> CMD_OUT; ENTER in DEST -> CMD_OUT.
REQ-025 CMD_OUT: cmd_valid=1, outputs frozen until cmd_ready=1 sampled; then cmd_valid=0, menu/amount/dest fields cleared, -> MENU (login fields retained).
REQ-026 Keys other than CANCEL arriving in LOGIN_OUT/CMD_OUT: ignored silently.
REQ-027 CANCEL in any state: exit pulse, all fields and valids cleared, -> ACC; CANCEL overrides a same-cycle ready (offer dropped, not accepted).
REQ-028 key_code 13-15: ignored, entry_error pulse.
REQ-029 Outputs registered; field outputs reflect live accumulator values at all times.

Reset
REQ-030 reset_n=0 asynchronously forces state ACC, all fields 0, login_valid=0, cmd_valid=0, exit=0, entry_error=0.
REQ-031 Keys during reset ignored; first key accepted on first rising edge with reset_n=1.
REQ-032 Reset mid-handshake drops the offer with no accept.

Verification
REQ-033 Keys 2,1,7,8,ENTER,4,ENTER -> login_valid=1, acc_number=2178, pin=4; login_ready=1 -> login_valid=0, state MENU.
REQ-034 After login: 5,ENTER,1,0,0,ENTER -> cmd_valid=1, menu_option=5, amount=100; held until cmd_ready, then amount=0, MENU.
REQ-035 Menu 6: amount 5,0 ENTER, dest 2,8,1,6 ENTER -> cmd_valid=1, amount=50, dest_acc_number=2816.
REQ-036 Amount keys 2,5,5 then 0 -> amount=255, entry_error pulse on the 0 (2550>2047); then CLEAR -> amount=0.
REQ-037 In ACC: ENTER alone -> entry_error; keys 4,0,9,6 -> 409 then 6 rejected (4096>4095) with entry_error.
REQ-038 CANCEL in CMD_OUT with cmd_ready=1 same cycle -> exit pulse, cmd_valid=0, all outputs 0, state ACC; reset_n low mid-entry -> all outputs 0 immediately.
